// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction ROM port, hazard/redirect controls and the IF/ID register outputs.
// The stage uses the slave view; the pipeline surroundings (ROM, hazard unit, later stages) use master.
interface if_stage_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  modport master (
    input  rom_addr, ifid_instr, ifid_pc_plus4, ifid_valid,
    output rom_data, stall, flush, redirect, redirect_pc, exc
  );

  modport slave (
    output rom_addr, ifid_instr, ifid_pc_plus4, ifid_valid,
    input  rom_data, stall, flush, redirect, redirect_pc, exc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction ROM and
// loads the IF/ID pipeline register. Next-PC priority is exception > redirect > stall > sequential.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h0000_0080,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      reset,
  if_stage_if.slave bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        kill;
  logic        unused_rpc_low;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect and exception squash the word fetched this cycle as well as a plain flush.
  assign kill = bus.exc | bus.redirect | bus.flush;

  // Redirect targets are forced word-aligned, so the low bits carry no information.
  assign unused_rpc_low = ^bus.redirect_pc[1:0];

  // NOTE: each always_comb output is defaulted before any branch; an unassigned path would infer a latch.
  always_comb begin
    pc_d = pc_plus4;
    if (bus.exc) begin
      pc_d = EXC_PC;
    end else if (bus.redirect) begin
      pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    if (kill) begin
      ifid_instr_d    = NOP_WORD;
      ifid_pc_plus4_d = pc_plus4;
      ifid_valid_d    = 1'b0;
    end else if (!bus.stall) begin
      ifid_instr_d    = bus.rom_data;
      ifid_pc_plus4_d = pc_plus4;
      ifid_valid_d    = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= NOP_WORD;
      ifid_pc_plus4_q <= 32'h0000_0000;
      ifid_valid_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

  assign bus.rom_addr      = pc_q;
  assign bus.ifid_instr    = ifid_instr_q;
  assign bus.ifid_pc_plus4 = ifid_pc_plus4_q;
  assign bus.ifid_valid    = ifid_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a reference model pushes the expected PC/IF-ID state to a
// scoreboard each cycle, popped after the edge; scenario tasks add fixed-value checks on top.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC   = 32'h0000_0080;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t m;
  exp_t sb[$];

  if_stage_if bus ();

  if_stage #(
    .RESET_PC(RESET_PC),
    .EXC_PC  (EXC_PC),
    .NOP_WORD(NOP_WORD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2004_0003;
      32'h0000_0010: return 32'h23BD_FFF8;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  // Drives one cycle of controls, checks nothing reacts before the edge, then scores the edge.
  task automatic step(input logic st, input logic fl, input logic rd,
                      input logic [31:0] rpc, input logic ex, input string tag);
    exp_t nx;
    exp_t got;
    bus.stall       = st;
    bus.flush       = fl;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.exc         = ex;
    #1;
    checks++;
    if (bus.rom_addr !== m.pc || bus.ifid_instr !== m.instr ||
        bus.ifid_pc_plus4 !== m.pp4 || bus.ifid_valid !== m.valid) begin
      errors++;
      $display("FAIL %s/pre_edge: got pc=%h instr=%h pp4=%h v=%b want pc=%h instr=%h pp4=%h v=%b",
               tag, bus.rom_addr, bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid,
               m.pc, m.instr, m.pp4, m.valid);
    end
    nx = m;
    if (ex)       nx.pc = EXC_PC;
    else if (rd)  nx.pc = {rpc[31:2], 2'b00};
    else if (!st) nx.pc = m.pc + 32'd4;
    if (ex || rd || fl) begin
      nx.instr = NOP_WORD;
      nx.valid = 1'b0;
      nx.pp4   = m.pc + 32'd4;
    end else if (!st) begin
      nx.instr = rom_word(m.pc);
      nx.valid = 1'b1;
      nx.pp4   = m.pc + 32'd4;
    end
    sb.push_back(nx);
    m = nx;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s/scoreboard: got empty queue want one entry", tag);
    end else begin
      got = sb.pop_front();
      if (bus.rom_addr !== got.pc || bus.ifid_instr !== got.instr ||
          bus.ifid_pc_plus4 !== got.pp4 || bus.ifid_valid !== got.valid) begin
        errors++;
        $display("FAIL %s/post_edge: got pc=%h instr=%h pp4=%h v=%b want pc=%h instr=%h pp4=%h v=%b",
                 tag, bus.rom_addr, bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid,
                 got.pc, got.instr, got.pp4, got.valid);
      end
    end
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, tag);
  endtask

  task automatic test_reset;
    reset           = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.exc         = 1'b0;
    m  = '{pc: RESET_PC, instr: NOP_WORD, pp4: 32'h0, valid: 1'b0};
    #2;
    checks++;
    if (bus.rom_addr !== 32'h0 || bus.ifid_instr !== 32'h0 ||
        bus.ifid_pc_plus4 !== 32'h0 || bus.ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got pc=%h instr=%h pp4=%h v=%b want all zero",
               bus.rom_addr, bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid);
    end
    #8;
    reset = 1'b1;
  endtask

  task automatic test_sequential;
    idle("seq0");
    checks++;
    if (bus.rom_addr !== 32'h4 || bus.ifid_instr !== 32'h2004_0003 ||
        bus.ifid_valid !== 1'b1 || bus.ifid_pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL seq_first_fetch: got pc=%h instr=%h v=%b pp4=%h want 00000004 20040003 1 00000004",
               bus.rom_addr, bus.ifid_instr, bus.ifid_valid, bus.ifid_pc_plus4);
    end
    idle("seq1");
    idle("seq2");
    checks++;
    if (bus.rom_addr !== 32'hC) begin
      errors++;
      $display("FAIL seq_addr: got %h want 0000000c", bus.rom_addr);
    end
  endtask

  task automatic test_redirect;
    step(1'b0, 1'b0, 1'b1, 32'h0000_0012, 1'b0, "redir");
    checks++;
    if (bus.rom_addr !== 32'h10 || bus.ifid_instr !== 32'h0 ||
        bus.ifid_valid !== 1'b0 || bus.ifid_pc_plus4 !== 32'h10) begin
      errors++;
      $display("FAIL redirect_bubble: got pc=%h instr=%h v=%b pp4=%h want 00000010 00000000 0 00000010",
               bus.rom_addr, bus.ifid_instr, bus.ifid_valid, bus.ifid_pc_plus4);
    end
    idle("redir_target");
    checks++;
    if (bus.ifid_instr !== 32'h23BD_FFF8 || bus.ifid_valid !== 1'b1 || bus.rom_addr !== 32'h14) begin
      errors++;
      $display("FAIL redirect_target: got instr=%h v=%b pc=%h want 23bdfff8 1 00000014",
               bus.ifid_instr, bus.ifid_valid, bus.rom_addr);
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "stall");
      checks++;
      if (bus.rom_addr !== 32'h14 || bus.ifid_instr !== 32'h23BD_FFF8 ||
          bus.ifid_pc_plus4 !== 32'h14 || bus.ifid_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got pc=%h instr=%h pp4=%h v=%b want 00000014 23bdfff8 00000014 1",
                 i, bus.rom_addr, bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid);
      end
    end
    idle("stall_resume");
    checks++;
    if (bus.rom_addr !== 32'h18 || bus.ifid_instr !== 32'hC0DE_0014 || bus.ifid_pc_plus4 !== 32'h18) begin
      errors++;
      $display("FAIL stall_resume: got pc=%h instr=%h pp4=%h want 00000018 c0de0014 00000018",
               bus.rom_addr, bus.ifid_instr, bus.ifid_pc_plus4);
    end
  endtask

  task automatic test_flush;
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, "flush");
    checks++;
    if (bus.rom_addr !== 32'h1C || bus.ifid_valid !== 1'b0 || bus.ifid_pc_plus4 !== 32'h1C) begin
      errors++;
      $display("FAIL flush_advance: got pc=%h v=%b pp4=%h want 0000001c 0 0000001c",
               bus.rom_addr, bus.ifid_valid, bus.ifid_pc_plus4);
    end
    idle("flush_after");
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, "flush_stall");
    checks++;
    if (bus.rom_addr !== 32'h20 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h0) begin
      errors++;
      $display("FAIL flush_stall: got pc=%h v=%b instr=%h want 00000020 0 00000000",
               bus.rom_addr, bus.ifid_valid, bus.ifid_instr);
    end
  endtask

  task automatic test_priority;
    step(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1, "exc_redir");
    checks++;
    if (bus.rom_addr !== 32'h80 || bus.ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL exc_over_redirect: got pc=%h v=%b want 00000080 0", bus.rom_addr, bus.ifid_valid);
    end
    idle("exc_after");
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, "stall_redir");
    checks++;
    if (bus.rom_addr !== 32'h40 || bus.ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_over_stall: got pc=%h v=%b want 00000040 0", bus.rom_addr, bus.ifid_valid);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "stall_exc");
    checks++;
    if (bus.rom_addr !== 32'h80) begin
      errors++;
      $display("FAIL exc_over_stall: got pc=%h want 00000080", bus.rom_addr);
    end
  endtask

  task automatic test_wrap;
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, "wrap_redir");
    idle("wrap");
    checks++;
    if (bus.rom_addr !== 32'h0 || bus.ifid_pc_plus4 !== 32'h0 ||
        bus.ifid_instr !== 32'hC0DE_FFFC || bus.ifid_valid !== 1'b1) begin
      errors++;
      $display("FAIL pc_wrap: got pc=%h pp4=%h instr=%h v=%b want 00000000 00000000 c0defffc 1",
               bus.rom_addr, bus.ifid_pc_plus4, bus.ifid_instr, bus.ifid_valid);
    end
  endtask

  task automatic test_reset_mid;
    idle("pre_rst0");
    idle("pre_rst1");
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.rom_addr !== 32'h0 || bus.ifid_valid !== 1'b0 ||
        bus.ifid_instr !== 32'h0 || bus.ifid_pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: got pc=%h v=%b instr=%h pp4=%h want all zero",
               bus.rom_addr, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_plus4);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.rom_addr !== 32'h0 || bus.ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got pc=%h v=%b want 00000000 0", bus.rom_addr, bus.ifid_valid);
    end
    #2;
    reset = 1'b1;
    m = '{pc: RESET_PC, instr: NOP_WORD, pp4: 32'h0, valid: 1'b0};
    sb.delete();
    idle("post_rst");
    checks++;
    if (bus.rom_addr !== 32'h4 || bus.ifid_instr !== 32'h2004_0003 || bus.ifid_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_restart: got pc=%h instr=%h v=%b want 00000004 20040003 1",
               bus.rom_addr, bus.ifid_instr, bus.ifid_valid);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom, $urandom_range(0, 9) == 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_flush();
    test_priority();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
